intl_latch_n: RTL and testbench

- Parametrised N-channel interlock capture block; the generalised successor of the fixed 4-ext + 4-HW interlock logic in the MPS INTL IP.
- Per-channel steps: synchronise, apply an active-level polarity, debounce by a programmable count, mask by bypass, then latch until a qualified clear.
- Also reports first-fault index and a saturating trip counter, for the PS over AXI register readback.

---
 rtl/intl_pkg.sv | 18 +
 rtl/intl_ch_filter.sv | 47 ++++
 rtl/intl_latch_n.sv | 129 ++++++++++++
 tb/tb_intl_latch_n.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/intl_pkg.sv
// Shared definitions for the interlock capture block: FSM encoding,
// synchroniser depth and an index-width helper.
package intl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_TRIP = 2'd1,
    ST_CLR  = 2'd2
  } intl_st_e;

  localparam int SYNC_STAGES = 2;

  // Index width that never collapses to zero for a single channel.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/intl_ch_filter.sv
// One interlock channel: synchroniser, polarity fold and debounce counter.
// o_trip_req stays high for every qualified cycle once the count is reached.
module intl_ch_filter
  import intl_pkg::*;
#(
  parameter int DBNC_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_raw,
  input  logic              i_pol,
  input  logic              i_bypass,
  input  logic [DBNC_W-1:0] i_dbnc_cnt,
  input  logic              i_clr,
  output logic              o_act,
  output logic              o_trip_req
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DBNC_W-1:0]      cnt_q, cnt_d, eff_cnt;
  logic                   live;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_raw};
      cnt_q  <= cnt_d;
    end
  end

  assign o_act   = sync_q[SYNC_STAGES-1] ^ ~i_pol;
  assign live    = o_act & ~i_bypass;
  assign eff_cnt = (i_dbnc_cnt == '0) ? DBNC_W'(1) : i_dbnc_cnt;

  // Compare one bit wider so cnt_q+1 cannot wrap at all-ones.
  assign o_trip_req = live &&
    (({1'b0, cnt_q} + (DBNC_W+1)'(1)) >= {1'b0, eff_cnt});

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr || !live)    cnt_d = '0;
    else if (cnt_q != '1)  cnt_d = cnt_q + DBNC_W'(1);
  end

endmodule

// File: rtl/intl_latch_n.sv
// N-channel interlock capture: per-channel filters, sticky trip latch,
// first-fault capture, saturating trip counter and qualified clear FSM.
module intl_latch_n
  import intl_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DBNC_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_CH-1:0]              i_intl_raw,
  input  logic [NUM_CH-1:0]              i_intl_pol,
  input  logic [NUM_CH-1:0]              i_intl_bypass,
  input  logic [DBNC_W-1:0]              i_dbnc_cnt,
  input  logic                           i_intl_rst,
  input  logic                           i_sys_rst_flag,
  output logic [NUM_CH-1:0]              o_intl_state,
  output logic                           o_intl_any,
  output logic [clog2_min1(NUM_CH)-1:0]  o_first_idx,
  output logic                           o_first_vld,
  output logic [CNT_W-1:0]               o_trip_cnt,
  output logic                           o_clr_reject
);

  localparam int IDX_W = clog2_min1(NUM_CH);

  intl_st_e               st_q, st_d;
  logic [NUM_CH-1:0]      act, trip_req, live, new_bits;
  logic [NUM_CH-1:0]      state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d, low_idx;
  logic                   vld_q, vld_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rej_q, rej_d;
  logic                   prst_q, sflag_prev_q;
  logic [SYNC_STAGES-1:0] sflag_q;
  logic                   in_clr, trip_ev, clr_ev;

  assign in_clr = (st_q == ST_CLR);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    intl_ch_filter #(.DBNC_W(DBNC_W)) u_flt (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_raw      (i_intl_raw[g]),
      .i_pol      (i_intl_pol[g]),
      .i_bypass   (i_intl_bypass[g]),
      .i_dbnc_cnt (i_dbnc_cnt),
      .i_clr      (in_clr),
      .o_act      (act[g]),
      .o_trip_req (trip_req[g])
    );
  end

  assign live     = act & ~i_intl_bypass;
  assign new_bits = trip_req & ~state_q & {NUM_CH{~in_clr}};
  assign trip_ev  = |new_bits;
  // Both clear sources OR into one event, so coincident edges count once.
  assign clr_ev   = (i_intl_rst & ~prst_q) |
                    (sflag_prev_q & ~sflag_q[SYNC_STAGES-1]);

  always_comb begin
    low_idx = '0;
    for (int i = NUM_CH-1; i >= 0; i--)
      if (new_bits[i]) low_idx = IDX_W'(i);
  end

  always_comb begin
    st_d  = st_q;
    rej_d = 1'b0;
    case (st_q)
      ST_RUN:  if (trip_ev) st_d = ST_TRIP;
      ST_TRIP: if (clr_ev) begin
                 // A trip in the same cycle is itself a live fault.
                 if (trip_ev || (|live)) rej_d = 1'b1;
                 else                    st_d  = ST_CLR;
               end
      ST_CLR:  st_d = ST_RUN;
      default: st_d = ST_RUN;
    endcase
  end

  always_comb begin
    state_d = in_clr ? '0 : (state_q | new_bits);
    idx_d   = idx_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    if (in_clr) begin
      idx_d = '0;
      vld_d = 1'b0;
    end else if (trip_ev && !vld_q) begin
      idx_d = low_idx;
      vld_d = 1'b1;
    end
    if (trip_ev && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      st_q         <= ST_RUN;
      state_q      <= '0;
      idx_q        <= '0;
      vld_q        <= 1'b0;
      cnt_q        <= '0;
      rej_q        <= 1'b0;
      prst_q       <= 1'b0;
      sflag_q      <= '0;
      sflag_prev_q <= 1'b0;
    end else begin
      st_q         <= st_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      vld_q        <= vld_d;
      cnt_q        <= cnt_d;
      rej_q        <= rej_d;
      prst_q       <= i_intl_rst;
      sflag_q      <= {sflag_q[SYNC_STAGES-2:0], i_sys_rst_flag};
      sflag_prev_q <= sflag_q[SYNC_STAGES-1];
    end
  end

  assign o_intl_state = state_q;
  assign o_intl_any   = |state_q;
  assign o_first_idx  = idx_q;
  assign o_first_vld  = vld_q;
  assign o_trip_cnt   = cnt_q;
  assign o_clr_reject = rej_q;

endmodule

// File: tb/tb_intl_latch_n.sv
// Directed bench for intl_latch_n; a second instance with a 2-bit trip
// counter shares the stimulus to exercise counter saturation.
module tb_intl_latch_n;

  logic        clk;
  logic        rst_n;
  logic [7:0]  raw, pol, byp;
  logic [15:0] dbnc;
  logic        intl_rst, sflag;

  logic [7:0]  st;
  logic        any, vld, rej;
  logic [2:0]  idx;
  logic [15:0] cnt;

  logic [7:0]  st2;
  logic        any2, vld2, rej2;
  logic [2:0]  idx2;
  logic [1:0]  cnt2;

  int checks = 0;
  int passed = 0;

  intl_latch_n #(.NUM_CH(8), .DBNC_W(16), .CNT_W(16)) u_dut (
    .i_clk(clk), .i_rst(rst_n), .i_intl_raw(raw), .i_intl_pol(pol),
    .i_intl_bypass(byp), .i_dbnc_cnt(dbnc), .i_intl_rst(intl_rst),
    .i_sys_rst_flag(sflag), .o_intl_state(st), .o_intl_any(any),
    .o_first_idx(idx), .o_first_vld(vld), .o_trip_cnt(cnt),
    .o_clr_reject(rej)
  );

  intl_latch_n #(.NUM_CH(8), .DBNC_W(16), .CNT_W(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst_n), .i_intl_raw(raw), .i_intl_pol(pol),
    .i_intl_bypass(byp), .i_dbnc_cnt(dbnc), .i_intl_rst(intl_rst),
    .i_sys_rst_flag(sflag), .o_intl_state(st2), .o_intl_any(any2),
    .o_first_idx(idx2), .o_first_vld(vld2), .o_trip_cnt(cnt2),
    .o_clr_reject(rej2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] d);
    rst_n = 1'b0; raw = '0; pol = 8'hFF; byp = '0; dbnc = d;
    intl_rst = 1'b0; sflag = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic clear_pulse();
    intl_rst = 1'b1; tick(1);
    intl_rst = 1'b0; tick(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; raw = 8'hFF; pol = 8'hFF; byp = '0; dbnc = 16'd1;
    intl_rst = 1'b0; sflag = 1'b1;
    tick(4);
    checks++; if (st !== 8'h00) $display("FAIL rst_state: got %h want 00", st); else passed++;
    checks++; if ({any, vld, rej} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {any, vld, rej}); else passed++;
    checks++; if ({idx, cnt} !== 19'd0) $display("FAIL rst_idx_cnt: got %0d/%0d want 0/0", idx, cnt); else passed++;
  endtask

  task automatic test_debounce();
    do_reset(16'd4);
    raw[3] = 1'b1; tick(3); raw[3] = 1'b0;
    tick(10);
    checks++; if (st !== 8'h00) $display("FAIL dbnc_glitch: got %h want 00", st); else passed++;
    raw[3] = 1'b1;
    tick(5);
    checks++; if (st !== 8'h00) $display("FAIL dbnc_early: got %h want 00 at edge 5", st); else passed++;
    tick(1);
    checks++; if (st !== 8'h08) $display("FAIL dbnc_state: got %h want 08 at edge 6", st); else passed++;
    checks++; if ({idx, vld, any} !== {3'd3, 1'b1, 1'b1}) $display("FAIL dbnc_first: got idx %0d vld %b any %b want 3 1 1", idx, vld, any); else passed++;
    checks++; if (cnt !== 16'd1) $display("FAIL dbnc_cnt: got %0d want 1", cnt); else passed++;
    // zero debounce count behaves as one: latency 3
    do_reset(16'd0);
    raw[5] = 1'b1;
    tick(2);
    checks++; if (st !== 8'h00) $display("FAIL dbnc0_early: got %h want 00", st); else passed++;
    tick(1);
    checks++; if (st !== 8'h20) $display("FAIL dbnc0_state: got %h want 20", st); else passed++;
  endtask

  task automatic test_priority();
    do_reset(16'd4);
    pol = 8'hDB;
    tick(4);
    checks++; if (st !== 8'h24) $display("FAIL prio_state: got %h want 24", st); else passed++;
    checks++; if ({idx, vld} !== {3'd2, 1'b1}) $display("FAIL prio_idx: got %0d vld %b want 2 1", idx, vld); else passed++;
    checks++; if (cnt !== 16'd1) $display("FAIL prio_cnt: got %0d want 1", cnt); else passed++;
    raw[7] = 1'b1;
    tick(8);
    checks++; if (st !== 8'hA4) $display("FAIL prio_state2: got %h want a4", st); else passed++;
    checks++; if (idx !== 3'd2) $display("FAIL prio_idx2: got %0d want 2", idx); else passed++;
    checks++; if (cnt !== 16'd2) $display("FAIL prio_cnt2: got %0d want 2", cnt); else passed++;
  endtask

  task automatic test_bypass();
    do_reset(16'd4);
    byp[1] = 1'b1; raw[1] = 1'b1;
    tick(100);
    checks++; if ({st, cnt} !== 24'd0) $display("FAIL byp_masked: got state %h cnt %0d want 00 0", st, cnt); else passed++;
    raw[4] = 1'b1;
    tick(8);
    checks++; if (st !== 8'h10) $display("FAIL byp_trip4: got %h want 10", st); else passed++;
    byp[4] = 1'b1;
    tick(5);
    checks++; if ({st, idx} !== {8'h10, 3'd4}) $display("FAIL byp_hold: got %h idx %0d want 10 4", st, idx); else passed++;
  endtask

  task automatic test_clear_qual();
    do_reset(16'd4);
    raw[0] = 1'b1;
    tick(8);
    checks++; if (st !== 8'h01) $display("FAIL clr_setup: got %h want 01", st); else passed++;
    intl_rst = 1'b1; tick(1);
    checks++; if ({rej, st} !== {1'b1, 8'h01}) $display("FAIL clr_reject: got rej %b state %h want 1 01", rej, st); else passed++;
    intl_rst = 1'b0; tick(1);
    checks++; if ({rej, st} !== {1'b0, 8'h01}) $display("FAIL clr_reject_pulse: got rej %b state %h want 0 01", rej, st); else passed++;
    raw[0] = 1'b0;
    tick(3);
    clear_pulse();
    checks++; if ({st, any, vld, idx} !== 13'd0) $display("FAIL clr_done: got state %h any %b vld %b idx %0d want all 0", st, any, vld, idx); else passed++;
    checks++; if ({cnt, rej} !== {16'd1, 1'b0}) $display("FAIL clr_cnt: got cnt %0d rej %b want 1 0", cnt, rej); else passed++;
    // a clear while idle changes nothing and is not rejected
    intl_rst = 1'b1; tick(1);
    checks++; if ({rej, st} !== 9'd0) $display("FAIL clr_idle: got rej %b state %h want 0 00", rej, st); else passed++;
    intl_rst = 1'b0; tick(1);
  endtask

  task automatic test_trip_clear_same();
    do_reset(16'd4);
    raw[0] = 1'b1; tick(8);
    raw[0] = 1'b0; tick(3);
    raw[6] = 1'b1;
    tick(5);
    intl_rst = 1'b1; tick(1);
    checks++; if ({st, rej} !== {8'h41, 1'b1}) $display("FAIL same_cycle: got state %h rej %b want 41 1", st, rej); else passed++;
    checks++; if ({idx, cnt} !== {3'd0, 16'd2}) $display("FAIL same_cycle_idx: got idx %0d cnt %0d want 0 2", idx, cnt); else passed++;
    intl_rst = 1'b0;
    tick(4);
    checks++; if (st !== 8'h41) $display("FAIL same_cycle_hold: got %h want 41", st); else passed++;
  endtask

  task automatic test_sys_flag();
    do_reset(16'd4);
    raw[2] = 1'b1; tick(8);
    raw[2] = 1'b0; tick(3);
    checks++; if (st !== 8'h04) $display("FAIL sflag_setup: got %h want 04", st); else passed++;
    sflag = 1'b0;
    tick(4);
    checks++; if ({st, vld} !== 9'd0) $display("FAIL sflag_clear: got state %h vld %b want 00 0", st, vld); else passed++;
    checks++; if (cnt !== 16'd1) $display("FAIL sflag_cnt: got %0d want 1", cnt); else passed++;
    sflag = 1'b1; tick(3);
  endtask

  task automatic test_saturate();
    do_reset(16'd4);
    for (int k = 0; k < 5; k++) begin
      raw[1] = 1'b1; tick(8);
      raw[1] = 1'b0; tick(3);
      clear_pulse();
    end
    checks++; if (cnt2 !== 2'd3) $display("FAIL sat_cnt2: got %0d want 3", cnt2); else passed++;
    checks++; if (cnt !== 16'd5) $display("FAIL sat_cnt16: got %0d want 5", cnt); else passed++;
  endtask

  task automatic test_async_reset();
    do_reset(16'd4);
    raw[3] = 1'b1; tick(8);
    checks++; if (st !== 8'h08) $display("FAIL arst_setup: got %h want 08", st); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({st, any, vld, rej} !== 11'd0) $display("FAIL arst_trip: got state %h any %b vld %b rej %b want 0", st, any, vld, rej); else passed++;
    checks++; if ({cnt, idx} !== 19'd0) $display("FAIL arst_cnt: got cnt %0d idx %0d want 0 0", cnt, idx); else passed++;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    // mid-debounce reset: counter restarts, still no trip
    rst_n = 1'b0; #1;
    checks++; if (st !== 8'h00) $display("FAIL arst_dbnc: got %h want 00", st); else passed++;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    checks++; if (st !== 8'h00) $display("FAIL arst_relat_early: got %h want 00", st); else passed++;
    tick(1);
    checks++; if ({st, cnt} !== {8'h08, 16'd1}) $display("FAIL arst_relat: got state %h cnt %0d want 08 1", st, cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_priority();
    test_bypass();
    test_clear_qual();
    test_trip_clear_same();
    test_sys_flag();
    test_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
